// File: rtl/cordic_pkg.sv
// rtl/cordic_pkg.sv - shared types, constants and helpers for the CORDIC job scheduler
package cordic_pkg;

    localparam int ANG_W  = 16;
    localparam int RES_W  = 16;
    localparam int DW     = 32;
    // Extra fraction bits carried by x/y beyond Q1.15 to keep truncation noise well below 1 LSB
    localparam int GUARD  = 8;

    localparam logic signed [RES_W-1:0] K_Q15      = 16'sh4DBA;
    localparam logic signed [RES_W-1:0] RES_MAX    = 16'sh7FFF;
    localparam logic signed [ANG_W-1:0] QUARTER    = 16'sh4000;
    localparam logic signed [DW-1:0]    X_INIT     = DW'(K_Q15) <<< GUARD;
    localparam logic signed [DW-1:0]    ROUND_HALF = 32'sd1 <<< (GUARD - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_LOAD = 2'd1,
        S_ITER = 2'd2,
        S_DONE = 2'd3
    } state_t;

    // atan(2^-i) in 32-bit binary-angle units (2^32 == 2*pi), matching the z scaling
    function automatic logic signed [DW-1:0] atan_at(input int i);
        case (i)
            0:       return 32'sh2000_0000;
            1:       return 32'sh12E4_051E;
            2:       return 32'sh09FB_385B;
            3:       return 32'sh0511_11D4;
            4:       return 32'sh028B_0D43;
            5:       return 32'sh0145_D7E1;
            6:       return 32'sh00A2_F61E;
            7:       return 32'sh0051_7C55;
            8:       return 32'sh0028_BE53;
            9:       return 32'sh0014_5F2F;
            10:      return 32'sh000A_2F98;
            11:      return 32'sh0005_17CC;
            12:      return 32'sh0002_8BE6;
            13:      return 32'sh0001_45F3;
            14:      return 32'sh0000_A2FA;
            15:      return 32'sh0000_517D;
            16:      return 32'sh0000_28BE;
            17:      return 32'sh0000_145F;
            18:      return 32'sh0000_0A30;
            19:      return 32'sh0000_0518;
            default: return 32'sh0000_0000;
        endcase
    endfunction

    // Drop guard bits with rounding, undo the half-turn fold, clamp to a symmetric Q1.15 range
    function automatic logic signed [RES_W-1:0] sat_result(input logic signed [DW-1:0] v,
                                                            input logic neg);
        logic signed [DW-1:0] r;
        r = (v + ROUND_HALF) >>> GUARD;
        if (neg) r = -r;
        if (r > 32'sd32767) return RES_MAX;
        if (r < -32'sd32767) return -RES_MAX;
        return r[RES_W-1:0];
    endfunction

endpackage

// File: rtl/cordic_rr_arbiter.sv
// rtl/cordic_rr_arbiter.sv - round-robin one-hot grant with pointer advance on accept
module cordic_rr_arbiter #(
    parameter int NCH = 4
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [NCH-1:0]          req,
    input  logic                    accept,
    output logic [NCH-1:0]          grant,
    output logic [$clog2(NCH)-1:0]  gnt_id
);
    localparam int IDW = $clog2(NCH);

    logic [IDW-1:0] ptr_q;
    logic [IDW-1:0] idx;
    logic           found;

    // First requester at or after the pointer wins
    always_comb begin
        grant  = '0;
        gnt_id = '0;
        idx    = '0;
        found  = 1'b0;
        for (int k = 0; k < NCH; k++) begin
            idx = IDW'((int'(ptr_q) + k) % NCH);
            if (!found && req[idx]) begin
                found      = 1'b1;
                grant[idx] = 1'b1;
                gnt_id     = idx;
            end
        end
    end

    // Pointer moves to the channel after the one just served
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr_q <= '0;
        end else if (accept) begin
            ptr_q <= (gnt_id == IDW'(NCH - 1)) ? '0 : gnt_id + IDW'(1);
        end
    end

endmodule

// File: rtl/cordic_sched.sv
// rtl/cordic_sched.sv - multi-channel CORDIC sin/cos job scheduler
module cordic_sched
    import cordic_pkg::*;
#(
    parameter int NCH  = 4,
    parameter int ITER = 16
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic [NCH-1:0]                req_valid,
    input  logic [NCH-1:0][ANG_W-1:0]     req_angle,
    output logic [NCH-1:0]                req_ready,
    output logic                          rsp_valid,
    input  logic                          rsp_ready,
    output logic [$clog2(NCH)-1:0]        rsp_id,
    output logic signed [RES_W-1:0]       rsp_sin,
    output logic signed [RES_W-1:0]       rsp_cos,
    output logic                          busy
);
    localparam int IDW = $clog2(NCH);
    localparam int CW  = $clog2(ITER) + 1;

    state_t               state, state_nxt;
    logic [NCH-1:0]       grant;
    logic [IDW-1:0]       gnt_id;
    logic                 accept;

    logic [ANG_W-1:0]     ang_q;
    logic [IDW-1:0]       id_q;
    logic                 neg_q;
    logic [CW-1:0]        cnt_q;
    logic signed [DW-1:0] x_q, y_q, z_q;
    logic signed [DW-1:0] x_rot, y_rot, z_rot;
    logic signed [DW-1:0] atan_i;
    logic                 fold;
    logic [ANG_W-1:0]     ang_fold;

    assign accept = (state == S_IDLE) && (|req_valid);

    cordic_rr_arbiter #(.NCH(NCH)) u_arb (
        .clk    (clk),
        .rst_n  (rst_n),
        .req    (req_valid),
        .accept (accept),
        .grant  (grant),
        .gnt_id (gnt_id)
    );

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= S_IDLE;
        else        state <= state_nxt;
    end

    // Next state and handshake/status outputs; grants are only offered in IDLE
    always_comb begin
        state_nxt = state;
        req_ready = '0;
        rsp_valid = 1'b0;
        busy      = 1'b1;
        case (state)
            S_IDLE: begin
                busy = 1'b0;
                if (rst_n) req_ready = grant;
                if (|req_valid) state_nxt = S_LOAD;
            end
            S_LOAD: state_nxt = S_ITER;
            S_ITER: if (cnt_q == CW'(ITER - 1)) state_nxt = S_DONE;
            S_DONE: begin
                rsp_valid = 1'b1;
                if (rsp_ready) state_nxt = S_IDLE;
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    // Quadrant fold: angles beyond +/-pi/2 are rotated by pi, which negates both results
    always_comb begin
        fold     = ($signed(ang_q) > QUARTER) || ($signed(ang_q) < -QUARTER);
        ang_fold = fold ? (ang_q ^ 16'h8000) : ang_q;
    end

    // One micro-rotation, direction chosen by the sign of the residual angle
    always_comb begin
        atan_i = atan_at(int'(cnt_q));
        if (!z_q[DW-1]) begin
            x_rot = x_q - (y_q >>> cnt_q);
            y_rot = y_q + (x_q >>> cnt_q);
            z_rot = z_q - atan_i;
        end else begin
            x_rot = x_q + (y_q >>> cnt_q);
            y_rot = y_q - (x_q >>> cnt_q);
            z_rot = z_q + atan_i;
        end
    end

    // Job capture and datapath registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ang_q <= '0;
            id_q  <= '0;
            neg_q <= 1'b0;
            cnt_q <= '0;
            x_q   <= '0;
            y_q   <= '0;
            z_q   <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (accept) begin
                        ang_q <= req_angle[gnt_id];
                        id_q  <= gnt_id;
                    end
                end
                S_LOAD: begin
                    x_q   <= X_INIT;
                    y_q   <= '0;
                    z_q   <= {ang_fold, {(DW - ANG_W){1'b0}}};
                    neg_q <= fold;
                    cnt_q <= '0;
                end
                S_ITER: begin
                    x_q   <= x_rot;
                    y_q   <= y_rot;
                    z_q   <= z_rot;
                    cnt_q <= cnt_q + CW'(1);
                end
                default: ;
            endcase
        end
    end

    // Result presentation, zero outside DONE
    always_comb begin
        rsp_id  = id_q;
        rsp_sin = '0;
        rsp_cos = '0;
        if (state == S_DONE) begin
            rsp_sin = sat_result(y_q, neg_q);
            rsp_cos = sat_result(x_q, neg_q);
        end
    end

endmodule

// File: tb/tb_cordic_sched.sv
// tb/tb_cordic_sched.sv - self-checking bench for cordic_sched
module tb_cordic_sched;
    localparam int NCH  = 4;
    localparam int ITER = 16;
    localparam int LAT  = ITER + 2;
    localparam int TOL  = 4;

    logic                       clk = 1'b0;
    logic                       rst_n;
    logic [NCH-1:0]             req_valid;
    logic [NCH-1:0][15:0]       req_angle;
    logic [NCH-1:0]             req_ready;
    logic                       rsp_valid;
    logic                       rsp_ready;
    logic [1:0]                 rsp_id;
    logic signed [15:0]         rsp_sin;
    logic signed [15:0]         rsp_cos;
    logic                       busy;

    int errors = 0;
    int checks = 0;
    int cyc    = 0;

    cordic_sched #(.NCH(NCH), .ITER(ITER)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (req_valid),
        .req_angle (req_angle),
        .req_ready (req_ready),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_id    (rsp_id),
        .rsp_sin   (rsp_sin),
        .rsp_cos   (rsp_cos),
        .busy      (busy)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Ideal sin/cos of a binary angle in Q1.15, clamped to +/-32767
    function automatic int ideal(input logic [15:0] ang, input bit want_sin);
        int  ai;
        real a, v;
        int  r;
        ai = $signed(ang);
        a  = real'(ai) * 3.14159265358979 / 32768.0;
        v  = want_sin ? $sin(a) : $cos(a);
        r  = int'(v * 32768.0);
        if (r > 32767) r = 32767;
        if (r < -32767) r = -32767;
        return r;
    endfunction

    function automatic bit close(input logic signed [15:0] got, input int exp);
        int d;
        d = int'(got) - exp;
        return (d <= TOL) && (d >= -TOL);
    endfunction

    task automatic run_job(input int ch, input logic [15:0] ang, output bit ok, output int lat,
                           output logic [1:0] id, output logic signed [15:0] s,
                           output logic signed [15:0] c);
        ok = 1'b0; lat = 0; id = '0; s = '0; c = '0;
        req_angle[ch] = ang;
        req_valid[ch] = 1'b1;
        for (int t = 0; t < 100 && !ok; t++) begin
            @(negedge clk);
            if (req_ready[ch]) ok = 1'b1;
        end
        @(posedge clk); #1;
        req_valid[ch] = 1'b0;
        if (!ok) return;
        ok = 1'b0;
        for (int t = 1; t < 60 && !ok; t++) begin
            @(negedge clk);
            if (rsp_valid) begin
                ok = 1'b1; lat = t; id = rsp_id; s = rsp_sin; c = rsp_cos;
            end
        end
        if (ok) begin
            @(posedge clk); #1;
        end
    endtask

    task automatic test_reset;
        rst_n = 1'b1;
        req_valid = '1;
        for (int i = 0; i < NCH; i++) req_angle[i] = 16'($urandom);
        #2 rst_n = 1'b0;
        repeat (3) @(negedge clk);
        checks++; if (req_ready !== 4'b0) begin errors++; $display("FAIL reset_req_ready: got %b want 0", req_ready); end
        checks++; if (rsp_valid !== 1'b0) begin errors++; $display("FAIL reset_rsp_valid: got %b want 0", rsp_valid); end
        checks++; if (rsp_id !== 2'd0) begin errors++; $display("FAIL reset_rsp_id: got %0d want 0", rsp_id); end
        checks++; if (rsp_sin !== 16'sd0) begin errors++; $display("FAIL reset_rsp_sin: got %0d want 0", rsp_sin); end
        checks++; if (rsp_cos !== 16'sd0) begin errors++; $display("FAIL reset_rsp_cos: got %0d want 0", rsp_cos); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", busy); end
        req_valid = '0;
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        checks++; if (busy !== 1'b0 || req_ready !== 4'b0) begin
            errors++; $display("FAIL idle_after_reset: busy %b ready %b want 0 0", busy, req_ready);
        end
    endtask

    // All four channels request together; ch0 re-requests right after its grant
    task automatic test_rr_order;
        int  exp_order [5] = '{0, 1, 2, 3, 0};
        int  last_c = 0;
        bit  found;
        logic [NCH-1:0] em;
        @(posedge clk); #1;
        for (int i = 0; i < NCH; i++) req_angle[i] = 16'($urandom);
        req_valid = '1;
        for (int g = 0; g < 5; g++) begin
            found = 1'b0;
            for (int w = 0; w < 60 && !found; w++) begin
                @(negedge clk);
                if (req_ready != '0) found = 1'b1;
            end
            em = NCH'(1) << exp_order[g];
            checks++; if (!found || req_ready !== em) begin
                errors++; $display("FAIL rr_grant%0d: got %b want %b", g, req_ready, em);
            end
            if (g > 0) begin
                checks++; if (cyc - last_c != ITER + 3) begin
                    errors++; $display("FAIL rr_gap%0d: got %0d cycles want %0d", g, cyc - last_c, ITER + 3);
                end
            end
            last_c = cyc;
            @(posedge clk); #1;
            req_valid[exp_order[g]] = 1'b0;
            if (g == 0) begin
                repeat (3) @(posedge clk);
                #1;
                req_angle[0] = 16'($urandom);
                req_valid[0] = 1'b1;
            end
        end
        found = 1'b0;
        for (int w = 0; w < 60 && !found; w++) begin
            @(negedge clk);
            if (rsp_valid) found = 1'b1;
        end
        checks++; if (!found || rsp_id !== 2'd0) begin
            errors++; $display("FAIL rr_last_rsp: seen %b id %0d want 1 0", found, rsp_id);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_single;
        bit ok; int lat; logic [1:0] id; logic signed [15:0] s, c;
        run_job(0, 16'h1555, ok, lat, id, s, c);
        checks++; if (!ok) begin errors++; $display("FAIL single_done: got timeout want response"); end
        checks++; if (lat != LAT) begin errors++; $display("FAIL single_latency: got %0d want %0d", lat, LAT); end
        checks++; if (id !== 2'd0) begin errors++; $display("FAIL single_id: got %0d want 0", id); end
        checks++; if (!close(s, 32'h4000)) begin errors++; $display("FAIL single_sin: got %0d want %0d +/-4", s, 32'h4000); end
        checks++; if (!close(c, 32'h6ED9)) begin errors++; $display("FAIL single_cos: got %0d want %0d +/-4", c, 32'h6ED9); end
    endtask

    task automatic test_boundaries;
        logic [15:0] angs [6] = '{16'h4000, 16'h8000, 16'hC000, 16'h0000, 16'h4001, 16'hBFFF};
        int          es   [6] = '{32767, 0, -32767, 0, 0, 0};
        int          ec   [6] = '{0, -32767, 0, 32767, 0, 0};
        bit ok; int lat; logic [1:0] id; logic signed [15:0] s, c;
        es[4] = ideal(angs[4], 1'b1); ec[4] = ideal(angs[4], 1'b0);
        es[5] = ideal(angs[5], 1'b1); ec[5] = ideal(angs[5], 1'b0);
        for (int i = 0; i < 6; i++) begin
            run_job(0, angs[i], ok, lat, id, s, c);
            checks++; if (!ok || !close(s, es[i])) begin
                errors++; $display("FAIL bound_sin_%h: got %0d want %0d +/-4", angs[i], s, es[i]);
            end
            checks++; if (!ok || !close(c, ec[i])) begin
                errors++; $display("FAIL bound_cos_%h: got %0d want %0d +/-4", angs[i], c, ec[i]);
            end
        end
    endtask

    task automatic test_stall;
        bit found; bit stable;
        logic signed [15:0] s0, c0;
        logic [15:0] ang;
        ang = 16'($urandom);
        rsp_ready = 1'b0;
        req_angle[1] = ang;
        req_valid[1] = 1'b1;
        found = 1'b0;
        for (int w = 0; w < 60 && !found; w++) begin
            @(negedge clk);
            if (req_ready[1]) found = 1'b1;
        end
        checks++; if (!found) begin errors++; $display("FAIL stall_grant: got none want ch1"); end
        @(posedge clk); #1;
        req_valid[1] = 1'b0;
        req_angle[3] = 16'h1555;
        req_valid[3] = 1'b1;
        found = 1'b0;
        for (int w = 0; w < 40 && !found; w++) begin
            @(negedge clk);
            if (rsp_valid) found = 1'b1;
        end
        s0 = rsp_sin; c0 = rsp_cos;
        checks++; if (!found || rsp_id !== 2'd1 || !close(s0, ideal(ang, 1'b1)) || !close(c0, ideal(ang, 1'b0))) begin
            errors++; $display("FAIL stall_result: id %0d sin %0d cos %0d want 1 %0d %0d", rsp_id, s0, c0,
                               ideal(ang, 1'b1), ideal(ang, 1'b0));
        end
        stable = 1'b1;
        for (int w = 0; w < 10; w++) begin
            @(negedge clk);
            if (rsp_valid !== 1'b1 || busy !== 1'b1 || req_ready !== 4'b0 ||
                rsp_sin !== s0 || rsp_cos !== c0 || rsp_id !== 2'd1) stable = 1'b0;
        end
        checks++; if (!stable) begin errors++; $display("FAIL stall_hold: got unstable outputs want held for 10 cycles"); end
        @(posedge clk); #1;
        rsp_ready = 1'b1;
        @(negedge clk);
        checks++; if (rsp_valid !== 1'b1) begin errors++; $display("FAIL stall_ready_cycle: rsp_valid %b want 1", rsp_valid); end
        @(negedge clk);
        checks++; if (req_ready !== 4'b1000 || busy !== 1'b0) begin
            errors++; $display("FAIL stall_next_grant: ready %b busy %b want 1000 0", req_ready, busy);
        end
        @(posedge clk); #1;
        req_valid[3] = 1'b0;
        found = 1'b0;
        for (int w = 0; w < 40 && !found; w++) begin
            @(negedge clk);
            if (rsp_valid) found = 1'b1;
        end
        checks++; if (!found || rsp_id !== 2'd3 || !close(rsp_sin, 32'h4000)) begin
            errors++; $display("FAIL stall_followup: id %0d sin %0d want 3 %0d", rsp_id, rsp_sin, 32'h4000);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_reset_mid;
        bit found; bit quiet;
        bit ok; int lat; logic [1:0] id; logic signed [15:0] s, c;
        req_angle[1] = 16'h2000;
        req_valid[1] = 1'b1;
        found = 1'b0;
        for (int w = 0; w < 60 && !found; w++) begin
            @(negedge clk);
            if (req_ready[1]) found = 1'b1;
        end
        @(posedge clk); #1;
        req_valid[1] = 1'b0;
        req_angle[3] = 16'h1000;
        req_valid[3] = 1'b1;
        repeat (9) @(negedge clk);
        checks++; if (!found || busy !== 1'b1) begin errors++; $display("FAIL midrst_running: busy %b want 1", busy); end
        #2 rst_n = 1'b0;
        #1;
        checks++; if (req_ready !== 4'b0 || rsp_valid !== 1'b0 || rsp_id !== 2'd0 ||
                      rsp_sin !== 16'sd0 || rsp_cos !== 16'sd0 || busy !== 1'b0) begin
            errors++; $display("FAIL midrst_outputs: ready %b valid %b id %0d sin %0d cos %0d busy %b want all 0",
                               req_ready, rsp_valid, rsp_id, rsp_sin, rsp_cos, busy);
        end
        repeat (2) @(negedge clk);
        req_valid[3] = 1'b0;
        rst_n = 1'b1;
        quiet = 1'b1;
        for (int w = 0; w < 20; w++) begin
            @(negedge clk);
            if (rsp_valid !== 1'b0 || busy !== 1'b0) quiet = 1'b0;
        end
        checks++; if (!quiet) begin errors++; $display("FAIL midrst_abort: got result or busy want none"); end
        run_job(2, 16'h1555, ok, lat, id, s, c);
        checks++; if (!ok || lat != LAT || id !== 2'd2) begin
            errors++; $display("FAIL midrst_job: ok %b lat %0d id %0d want 1 %0d 2", ok, lat, id, LAT);
        end
        checks++; if (!close(s, 32'h4000) || !close(c, 32'h6ED9)) begin
            errors++; $display("FAIL midrst_values: sin %0d cos %0d want %0d %0d", s, c, 32'h4000, 32'h6ED9);
        end
    endtask

    // Random multi-channel traffic against a queue-free single-job-in-flight model
    task automatic test_sweep;
        logic [15:0] corners [11] = '{16'h0000, 16'h4000, 16'h4001, 16'h3FFF, 16'h8000, 16'h8001,
                                      16'h7FFF, 16'hC000, 16'hBFFF, 16'hC001, 16'hFFFF};
        bit          pend [NCH];
        logic [15:0] pang [NCH];
        int issued = 0, done = 0, budget = 0;
        int mptr = 3;   // ch2 was the last channel granted before this task
        bit inflight = 1'b0;
        int fl_id = 0, fl_cyc = 0, eid, gid;
        logic [15:0] fl_ang = '0;
        logic [NCH-1:0] exp_g;
        for (int i = 0; i < NCH; i++) begin pend[i] = 1'b0; pang[i] = '0; end
        rsp_ready = 1'b1;
        req_valid = '0;
        while (done < 1000 && budget < 40000 && errors < 50) begin
            @(negedge clk);
            budget++;
            exp_g = '0; eid = -1; gid = -1;
            if (!inflight) begin
                for (int k = 0; k < NCH; k++) begin
                    if (eid < 0 && pend[(mptr + k) % NCH]) eid = (mptr + k) % NCH;
                end
                if (eid >= 0) exp_g[eid] = 1'b1;
            end
            checks++; if (req_ready !== exp_g) begin
                errors++; $display("FAIL sweep_grant: got %b want %b", req_ready, exp_g);
            end
            if (eid >= 0) begin
                inflight = 1'b1; fl_id = eid; fl_ang = pang[eid]; fl_cyc = cyc;
                pend[eid] = 1'b0; mptr = (eid + 1) % NCH; gid = eid;
            end
            if (rsp_valid) begin
                checks++; if (!inflight) begin
                    errors++; $display("FAIL sweep_spurious: got rsp id %0d want none", rsp_id);
                end else begin
                    checks++; if (int'(rsp_id) != fl_id || cyc - fl_cyc != LAT) begin
                        errors++; $display("FAIL sweep_id_lat: id %0d lat %0d want %0d %0d", rsp_id, cyc - fl_cyc, fl_id, LAT);
                    end
                    checks++; if (!close(rsp_sin, ideal(fl_ang, 1'b1)) || rsp_sin === 16'sh8000) begin
                        errors++; $display("FAIL sweep_sin_%h: got %0d want %0d +/-4", fl_ang, rsp_sin, ideal(fl_ang, 1'b1));
                    end
                    checks++; if (!close(rsp_cos, ideal(fl_ang, 1'b0)) || rsp_cos === 16'sh8000) begin
                        errors++; $display("FAIL sweep_cos_%h: got %0d want %0d +/-4", fl_ang, rsp_cos, ideal(fl_ang, 1'b0));
                    end
                    inflight = 1'b0;
                    done++;
                end
            end
            @(posedge clk); #1;
            if (gid >= 0) req_valid[gid] = 1'b0;
            for (int ch = 0; ch < NCH; ch++) begin
                if (!pend[ch] && issued < 1000 && $urandom_range(0, 3) == 0) begin
                    pend[ch] = 1'b1;
                    if ($urandom_range(0, 7) == 0) pang[ch] = corners[$urandom_range(0, 10)];
                    else pang[ch] = 16'($urandom);
                    req_angle[ch] = pang[ch];
                    req_valid[ch] = 1'b1;
                    issued++;
                end
            end
        end
        checks++; if (done != 1000 || issued != 1000) begin
            errors++; $display("FAIL sweep_count: done %0d issued %0d want 1000 1000", done, issued);
        end
    endtask

    initial begin
        rst_n     = 1'b1;
        req_valid = '0;
        req_angle = '0;
        rsp_ready = 1'b1;
        test_reset;
        test_rr_order;
        test_single;
        test_boundaries;
        test_stall;
        test_reset_mid;
        test_sweep;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #700000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1);
    end

endmodule
